load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Memory-stage load/store unit of the RV32I core. It is the producer of the load data that writeback selects with mem_to_reg=01.
- Takes effective address (alu_out), store data (rs2) and funct3 from execute.
- Drives a req/ack data-memory port with byte enables.
- Returns an aligned, sign/zero-extended load word on data_mem_out.
- Stalls the pipeline while an access is outstanding.

Parameters:
- DataWidth, 32, data and register width (fixed at 32 for RV32I byte-lane logic).
- AddrWidth, 32, data-memory address width.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- mem_read  in  1  load instruction in memory stage.
- mem_write  in  1  store instruction in memory stage.
- funct3  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- alu_out  in  AddrWidth  effective byte address.
- rs2_data  in  DataWidth  store source data.
- stall  out  1  freeze upstream pipeline stages.
- data_mem_out  out  DataWidth  formatted load result, registered.
- lsu_done  out  1  one-cycle pulse when access completes.
- lsu_err  out  1  one-cycle pulse on misaligned or illegal access.
- dmem_req  out  1  memory request, held until ack.
- dmem_we  out  1  1 = write.
- dmem_addr  out  AddrWidth  word-aligned address (addr[1:0]=00).
- dmem_wdata  out  DataWidth  lane-replicated store data.
- dmem_be  out  4  byte enables.
- dmem_rdata  in  DataWidth  read data, valid with ack.
- dmem_ack  in  1  access complete.

Behaviour:
- Reset: state=IDLE. stall, lsu_done, lsu_err, dmem_req, dmem_we = 0. dmem_addr, dmem_wdata, data_mem_out = 0. dmem_be = 0000.
- FSM states: IDLE, BUSY, DONE.
- IDLE, valid access (mem_read xor mem_write, legal funct3, aligned):
  - Register address/data/be/we and funct3; go to BUSY.
  - dmem_req=1 from the next cycle.
  - stall is high combinationally in this cycle.
- BUSY:
  - dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be held stable; stall=1.
  - dmem_ack is sampled only while dmem_req=1, so an ack in the first BUSY cycle completes the access.
  - On ack: dmem_req drops next edge. For loads, data_mem_out is updated with the formatted dmem_rdata. Go to DONE.
- DONE: lsu_done=1, stall=0, so the pipeline advances at the end of this cycle. Memory-stage inputs are ignored. Next state is IDLE.
- Latency with zero-wait memory: request seen at cycle 0, req at cycle 1, ack at cycle 1, DONE at cycle 2. Total stall is 2 cycles; each wait cycle adds one.
- Alignment: H/HU needs addr[0]=0; W needs addr[1:0]=00. B is always aligned.
- Error cases, all giving a lsu_err pulse on the next cycle, no memory request, no stall, data_mem_out unchanged:
  - misaligned address;
  - illegal funct3 (loads: 011, 110, 111; stores: anything above 010);
  - mem_read and mem_write both high.
- Store lane rules:
  - SB: be=0001<<addr[1:0], wdata={4{rs2[7:0]}}.
  - SH: be=0011<<addr[1:0], wdata={2{rs2[15:0]}}.
  - SW: be=1111, wdata=rs2.
- Loads: dmem_be=1111.
  - LB/LBU: byte at addr[1:0], sign- or zero-extended.
  - LH/LHU: half at addr[1], sign- or zero-extended.
  - LW: full word.
- Reset mid-access: back to IDLE, dmem_req=0 next edge. A late ack in IDLE is ignored; no lsu_done.
- A spurious dmem_ack in IDLE or DONE is ignored.

Decomposition:
- Package lsu_pkg:
  - funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU;
  - lsu_state_e enum {IDLE, BUSY, DONE};
  - be-generation function.
- Sub-module load_formatter (combinational): inputs dmem_rdata, offset[1:0], funct3; output the extended word. The unit instantiates it in front of the data_mem_out register.

Test Plan:
- SW rs2=0xDEADBEEF at 0x100, ack one cycle after req → dmem_be=1111, dmem_addr=0x100, wdata=0xDEADBEEF; stall high 2 cycles; lsu_done pulse.
- SB rs2=0x123456A5 at 0x103 → dmem_be=1000, dmem_addr=0x100, dmem_wdata=0xA5A5A5A5.
- LB at 0x102, rdata=0x1280FF00 → data_mem_out=0xFFFFFF80. Repeat as LBU → 0x00000080. LHU at 0x102 → 0x00001280.
- LH at 0x101 → lsu_err pulse, dmem_req never rises, stall stays 0, data_mem_out unchanged.
- LW with ack delayed 3 cycles → stall and dmem_req high throughout, addr stable; data_mem_out updates one edge after ack.
- rst asserted mid-BUSY, then ack arrives → dmem_req=0 after reset edge; no lsu_done; all outputs at reset values.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types, funct3 encodings and lane helpers for the RV32I load/store unit.
package lsu_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 32;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } lsu_state_e;

    // Store byte enables for a given access size and byte offset.
    function automatic logic [3:0] gen_be(input logic [2:0] f3, input logic [1:0] off);
        case (f3[1:0])
            2'b00:   gen_be = 4'b0001 << off;
            2'b01:   gen_be = 4'b0011 << off;
            default: gen_be = 4'b1111;
        endcase
    endfunction

    // Replicate store data across every lane the access could land on.
    function automatic logic [DATA_W-1:0] lane_data(input logic [2:0] f3, input logic [DATA_W-1:0] d);
        case (f3[1:0])
            2'b00:   lane_data = {4{d[7:0]}};
            2'b01:   lane_data = {2{d[15:0]}};
            default: lane_data = d;
        endcase
    endfunction

endpackage

// File: rtl/load_formatter.sv
// Selects the addressed byte/half of a read word and sign- or zero-extends it.
module load_formatter
    import lsu_pkg::*;
(
    input  logic [DATA_W-1:0] dmem_rdata,
    input  logic [1:0]        offset,
    input  logic [2:0]        funct3,
    output logic [DATA_W-1:0] load_data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (offset)
            2'd0:    byte_sel = dmem_rdata[7:0];
            2'd1:    byte_sel = dmem_rdata[15:8];
            2'd2:    byte_sel = dmem_rdata[23:16];
            default: byte_sel = dmem_rdata[31:24];
        endcase
        half_sel = offset[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];

        case (funct3)
            F3_B:    load_data = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   load_data = {24'd0, byte_sel};
            F3_H:    load_data = {{16{half_sel[15]}}, half_sel};
            F3_HU:   load_data = {16'd0, half_sel};
            default: load_data = dmem_rdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: validates the access, runs one req/ack
// transaction on the data-memory port and formats the load result.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned DataWidth = DATA_W,
    parameter int unsigned AddrWidth = ADDR_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 mem_read,
    input  logic                 mem_write,
    input  logic [2:0]           funct3,
    input  logic [AddrWidth-1:0] alu_out,
    input  logic [DataWidth-1:0] rs2_data,
    output logic                 stall,
    output logic [DataWidth-1:0] data_mem_out,
    output logic                 lsu_done,
    output logic                 lsu_err,
    output logic                 dmem_req,
    output logic                 dmem_we,
    output logic [AddrWidth-1:0] dmem_addr,
    output logic [DataWidth-1:0] dmem_wdata,
    output logic [3:0]           dmem_be,
    input  logic [DataWidth-1:0] dmem_rdata,
    input  logic                 dmem_ack
);

    lsu_state_e state, state_nxt;

    logic              f3_legal;
    logic              aligned;
    logic              access_ok;
    logic              access_bad;
    logic [2:0]        f3_q;
    logic [1:0]        off_q;
    logic [DATA_W-1:0] fmt_data;

    // Access decode: exactly one of read/write, legal size for the direction, aligned.
    always_comb begin
        f3_legal = 1'b0;
        aligned  = 1'b0;
        case (funct3)
            F3_B, F3_H, F3_W: f3_legal = 1'b1;
            F3_BU, F3_HU:     f3_legal = mem_read;
            default:          f3_legal = 1'b0;
        endcase
        case (funct3[1:0])
            2'b00:   aligned = 1'b1;
            2'b01:   aligned = ~alu_out[0];
            2'b10:   aligned = (alu_out[1:0] == 2'b00);
            default: aligned = 1'b0;
        endcase
        access_ok  = (mem_read ^ mem_write) & f3_legal & aligned;
        access_bad = (mem_read | mem_write) & ~access_ok;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Stall covers the accepting cycle combinationally, then every BUSY cycle.
    always_comb begin
        state_nxt = state;
        stall     = 1'b0;
        case (state)
            IDLE: begin
                if (access_ok) begin
                    state_nxt = BUSY;
                    stall     = 1'b1;
                end
            end
            BUSY: begin
                stall = 1'b1;
                if (dmem_req && dmem_ack) begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    load_formatter u_fmt (
        .dmem_rdata (dmem_rdata),
        .offset     (off_q),
        .funct3     (f3_q),
        .load_data  (fmt_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            lsu_done     <= 1'b0;
            lsu_err      <= 1'b0;
            dmem_req     <= 1'b0;
            dmem_we      <= 1'b0;
            dmem_addr    <= '0;
            dmem_wdata   <= '0;
            dmem_be      <= 4'b0000;
            data_mem_out <= '0;
            f3_q         <= 3'd0;
            off_q        <= 2'd0;
        end else begin
            lsu_done <= 1'b0;
            lsu_err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (access_ok) begin
                        dmem_req  <= 1'b1;
                        dmem_we   <= mem_write;
                        dmem_addr <= {alu_out[AddrWidth-1:2], 2'b00};
                        dmem_be   <= mem_write ? gen_be(funct3, alu_out[1:0]) : 4'b1111;
                        f3_q      <= funct3;
                        off_q     <= alu_out[1:0];
                        if (mem_write) begin
                            dmem_wdata <= lane_data(funct3, rs2_data);
                        end
                    end else if (access_bad) begin
                        lsu_err <= 1'b1;
                    end
                end
                BUSY: begin
                    if (dmem_req && dmem_ack) begin
                        dmem_req <= 1'b0;
                        lsu_done <= 1'b1;
                        if (!dmem_we) begin
                            data_mem_out <= fmt_data;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: transaction-level model plus
// directed accesses with hand-computed results.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [2:0]  funct3 = 3'd0;
    logic [31:0] alu_out = '0;
    logic [31:0] rs2_data = '0;
    logic        stall;
    logic [31:0] data_mem_out;
    logic        lsu_done;
    logic        lsu_err;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_rdata = '0;
    logic        dmem_ack = 1'b0;

    int errors = 0;
    int checks = 0;
    bit checks_on = 0;

    load_store_unit dut (
        .clk          (clk),
        .rst          (rst),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .funct3       (funct3),
        .alu_out      (alu_out),
        .rs2_data     (rs2_data),
        .stall        (stall),
        .data_mem_out (data_mem_out),
        .lsu_done     (lsu_done),
        .lsu_err      (lsu_err),
        .dmem_req     (dmem_req),
        .dmem_we      (dmem_we),
        .dmem_addr    (dmem_addr),
        .dmem_wdata   (dmem_wdata),
        .dmem_be      (dmem_be),
        .dmem_rdata   (dmem_rdata),
        .dmem_ack     (dmem_ack)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int size_bytes(input logic [2:0] f3);
        if (f3[1:0] == 2'b00) return 1;
        if (f3[1:0] == 2'b01) return 2;
        return 4;
    endfunction

    function automatic bit legal(input bit rd, input bit wr, input logic [2:0] f3, input logic [31:0] a);
        if (rd == wr) return 0;
        if (wr && f3 > 3'd2) return 0;
        if (rd && (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7)) return 0;
        return (a % size_bytes(f3)) == 0;
    endfunction

    function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [31:0] a);
        int sz;
        sz = size_bytes(f3);
        return 4'(((1 << sz) - 1) << (a % 4));
    endfunction

    function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] d);
        int sz;
        sz = size_bytes(f3);
        if (sz == 1) return 32'(d[7:0]) * 32'h0101_0101;
        if (sz == 2) return 32'(d[15:0]) * 32'h0001_0001;
        return d;
    endfunction

    function automatic logic [31:0] extend(input logic [31:0] rd, input logic [2:0] f3, input logic [1:0] off);
        int sz;
        longint unsigned v;
        sz = size_bytes(f3);
        v  = (64'(rd) >> (8 * off)) % (64'd1 << (8 * sz));
        if (!f3[2] && sz < 4 && v >= (64'd1 << (8 * sz - 1))) v = v - (64'd1 << (8 * sz));
        return 32'(v);
    endfunction

    int          m_phase;   // 0 waiting for an access, 1 memory outstanding, 2 completing
    logic [2:0]  m_f3;
    logic [1:0]  m_off;
    logic        e_req, e_we, e_done, e_err;
    logic [31:0] e_addr, e_wdata, e_dout;
    logic [3:0]  e_be;

    always @(posedge clk) begin
        if (rst) begin
            m_phase <= 0;
            e_req <= 0; e_we <= 0; e_done <= 0; e_err <= 0;
            e_addr <= '0; e_wdata <= '0; e_dout <= '0; e_be <= 4'd0;
            m_f3 <= 3'd0; m_off <= 2'd0;
        end else begin
            e_done <= 0;
            e_err  <= 0;
            if (m_phase == 0) begin
                if (legal(mem_read, mem_write, funct3, alu_out)) begin
                    m_phase <= 1;
                    e_req   <= 1;
                    e_we    <= mem_write;
                    e_addr  <= alu_out & ~32'd3;
                    e_be    <= mem_write ? model_be(funct3, alu_out) : 4'b1111;
                    m_f3    <= funct3;
                    m_off   <= 2'(alu_out % 4);
                    if (mem_write) e_wdata <= model_wdata(funct3, rs2_data);
                end else if (mem_read || mem_write) begin
                    e_err <= 1;
                end
            end else if (m_phase == 1) begin
                if (dmem_ack) begin
                    m_phase <= 2;
                    e_req   <= 0;
                    e_done  <= 1;
                    if (!e_we) e_dout <= extend(dmem_rdata, m_f3, m_off);
                end
            end else begin
                m_phase <= 0;
            end
        end
    end

    // Cycle-by-cycle comparison against the model
    always @(negedge clk) begin
        if (checks_on) begin
            chk("stall", 32'(stall), 32'((m_phase == 1) ||
                (m_phase == 0 && legal(mem_read, mem_write, funct3, alu_out))));
            chk("dmem_req", 32'(dmem_req), 32'(e_req));
            chk("lsu_done", 32'(lsu_done), 32'(e_done));
            chk("lsu_err", 32'(lsu_err), 32'(e_err));
            chk("data_mem_out", data_mem_out, e_dout);
            if (e_req) begin
                chk("dmem_we", 32'(dmem_we), 32'(e_we));
                chk("dmem_addr", dmem_addr, e_addr);
                chk("dmem_be", 32'(dmem_be), 32'(e_be));
                if (e_we) chk("dmem_wdata", dmem_wdata, e_wdata);
            end
        end
    end

    // ---------------- directed stimulus ----------------
    int          stall_cnt, req_cnt, done_cnt, err_cnt;
    logic [31:0] cap_addr, cap_wdata;
    logic [3:0]  cap_be;

    // Present one access for a single cycle; ack arrives w cycles after the first req cycle.
    task automatic run_access(input bit rd, input bit wr, input logic [2:0] f3,
                              input logic [31:0] addr, input logic [31:0] data,
                              input int w, input logic [31:0] rdata);
        stall_cnt = 0; req_cnt = 0; done_cnt = 0; err_cnt = 0;
        mem_read = rd; mem_write = wr; funct3 = f3; alu_out = addr; rs2_data = data;
        for (int k = 0; k < w + 4; k++) begin
            if (k == w + 1) begin
                dmem_ack   = 1'b1;
                dmem_rdata = rdata;
            end
            @(negedge clk);
            if (stall)    stall_cnt++;
            if (dmem_req) req_cnt++;
            if (lsu_done) done_cnt++;
            if (lsu_err)  err_cnt++;
            if (k == 1) begin
                cap_addr = dmem_addr; cap_be = dmem_be; cap_wdata = dmem_wdata;
            end
            @(posedge clk); #1;
            mem_read = 1'b0; mem_write = 1'b0;
            dmem_ack = 1'b0; dmem_rdata = $urandom;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("reset stall", 32'(stall), 32'd0);
        chk("reset dmem_req", 32'(dmem_req), 32'd0);
        chk("reset dmem_we", 32'(dmem_we), 32'd0);
        chk("reset lsu_done", 32'(lsu_done), 32'd0);
        chk("reset lsu_err", 32'(lsu_err), 32'd0);
        chk("reset dmem_addr", dmem_addr, 32'd0);
        chk("reset dmem_wdata", dmem_wdata, 32'd0);
        chk("reset data_mem_out", data_mem_out, 32'd0);
        chk("reset dmem_be", 32'(dmem_be), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        checks_on = 1;

        // SW, zero-wait memory
        run_access(1'b0, 1'b1, 3'b010, 32'h100, 32'hDEAD_BEEF, 0, 32'h0);
        chk("sw be", 32'(cap_be), 32'hF);
        chk("sw addr", cap_addr, 32'h100);
        chk("sw wdata", cap_wdata, 32'hDEAD_BEEF);
        chk("sw stall cycles", 32'(stall_cnt), 32'd2);
        chk("sw done pulses", 32'(done_cnt), 32'd1);
        chk("sw req cycles", 32'(req_cnt), 32'd1);

        // SB to top lane
        run_access(1'b0, 1'b1, 3'b000, 32'h103, 32'h1234_56A5, 0, 32'h0);
        chk("sb be", 32'(cap_be), 32'h8);
        chk("sb addr", cap_addr, 32'h100);
        chk("sb wdata", cap_wdata, 32'hA5A5_A5A5);

        // SH to upper half
        run_access(1'b0, 1'b1, 3'b001, 32'h102, 32'h0000_BEEF, 1, 32'h0);
        chk("sh be", 32'(cap_be), 32'hC);
        chk("sh wdata", cap_wdata, 32'hBEEF_BEEF);

        // Byte/half loads from one read word
        run_access(1'b1, 1'b0, 3'b000, 32'h102, 32'h1280_FF00, 0, 32'h1280_FF00);
        chk("lb result", data_mem_out, 32'hFFFF_FF80);
        chk("lb be", 32'(cap_be), 32'hF);
        run_access(1'b1, 1'b0, 3'b100, 32'h102, 32'h0, 0, 32'h1280_FF00);
        chk("lbu result", data_mem_out, 32'h0000_0080);
        run_access(1'b1, 1'b0, 3'b101, 32'h102, 32'h0, 0, 32'h1280_FF00);
        chk("lhu result", data_mem_out, 32'h0000_1280);
        run_access(1'b1, 1'b0, 3'b001, 32'h102, 32'h0, 0, 32'h8001_0000);
        chk("lh result", data_mem_out, 32'hFFFF_8001);

        // Misaligned LH, with a stray ack while idle
        run_access(1'b1, 1'b0, 3'b001, 32'h101, 32'h0, 0, 32'h7777_7777);
        chk("lh misaligned err", 32'(err_cnt), 32'd1);
        chk("lh misaligned req", 32'(req_cnt), 32'd0);
        chk("lh misaligned stall", 32'(stall_cnt), 32'd0);
        chk("lh misaligned done", 32'(done_cnt), 32'd0);
        chk("lh misaligned keeps data", data_mem_out, 32'hFFFF_8001);

        // Illegal store size, read+write together, misaligned LW
        run_access(1'b0, 1'b1, 3'b100, 32'h100, 32'h1, 0, 32'h0);
        chk("illegal store err", 32'(err_cnt), 32'd1);
        chk("illegal store req", 32'(req_cnt), 32'd0);
        run_access(1'b1, 1'b1, 3'b010, 32'h100, 32'h1, 0, 32'h0);
        chk("rd+wr err", 32'(err_cnt), 32'd1);
        run_access(1'b1, 1'b0, 3'b010, 32'h102, 32'h0, 0, 32'h0);
        chk("lw misaligned err", 32'(err_cnt), 32'd1);
        chk("lw misaligned data", data_mem_out, 32'hFFFF_8001);

        // LW with a slow memory
        run_access(1'b1, 1'b0, 3'b010, 32'h204, 32'h0, 3, 32'hCAFE_F00D);
        chk("lw slow stall cycles", 32'(stall_cnt), 32'd5);
        chk("lw slow req cycles", 32'(req_cnt), 32'd4);
        chk("lw slow addr", cap_addr, 32'h204);
        chk("lw slow result", data_mem_out, 32'hCAFE_F00D);

        // Reset while BUSY, then a late ack
        mem_read = 1'b1; funct3 = 3'b010; alu_out = 32'h200;
        @(posedge clk); #1;
        mem_read = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        dmem_ack = 1'b1; dmem_rdata = 32'h5555_AAAA;
        @(negedge clk);
        chk("post-reset req", 32'(dmem_req), 32'd0);
        chk("post-reset done", 32'(lsu_done), 32'd0);
        @(posedge clk); #1;
        dmem_ack = 1'b0;
        @(negedge clk);
        chk("late ack done", 32'(lsu_done), 32'd0);
        chk("late ack req", 32'(dmem_req), 32'd0);
        chk("late ack stall", 32'(stall), 32'd0);
        chk("late ack data", data_mem_out, 32'd0);
        chk("late ack be", 32'(dmem_be), 32'd0);
        chk("late ack addr", dmem_addr, 32'd0);
        @(posedge clk); #1;

        checks_on = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
